display_scheduler: RTL
======================

Name: display_scheduler

Overview:
- Round-robin scheduler that shares the single double 7-segment display path (binary → BCD → segment decoder) among up to N_REQ requesters.
- Each requester offers a 4-bit value through a valid/ready handshake.
- The granted value drives the decoder input for exactly HOLD_CYCLES clocks, then the next pending requester is granted.
- The display path is blanked when no value is being shown.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- HOLD_CYCLES, 50_000_000, clocks each accepted value stays displayed (≥1; 1 s at 50 MHz).
- SRC_W, $clog2(N_REQ), width of the source index (derived; not overridden).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  N_REQ  bit i: requester i offers a value.
- req_value  in  4*N_REQ  requester i value in bits [4i+3:4i], range 0..15.
- freeze  in  1  pauses scheduling and hold countdown.
- req_ready  out  N_REQ  one-hot grant; transfer when req_valid[i]&req_ready[i] at a clk edge.
- disp_value  out  4  value to the display decoder's 4-bit binary input.
- disp_src  out  SRC_W  index of the requester whose value is displayed.
- disp_blank  out  1  1 = display must be blanked (no value shown).
- busy  out  1  1 while in SHOW.

Behaviour:
- Reset (async, immediate, any cycle, including mid-hold):
  - state=IDLE, disp_value=0, disp_src=0, disp_blank=1, busy=0, counter=0.
  - last_grant=N_REQ-1, so requester 0 wins first.
  - req_ready=0 while rst=1.
- States:
  - IDLE: nothing shown; disp_blank=1.
  - SHOW: value held; disp_blank=0; busy=1.
- Arbitration (combinational):
  - Search order last_grant+1, last_grant+2, … modulo N_REQ; first asserted req_valid wins.
  - Grant window: (IDLE or (SHOW and counter==0)) and freeze=0.
  - In the grant window the winner's req_ready=1; all other req_ready bits are 0 at all times.
- On transfer edge:
  - disp_value ← winner's value; disp_src ← winner; last_grant ← winner.
  - counter ← HOLD_CYCLES-1; state ← SHOW.
  - Latency: value visible on disp_value the cycle after the transfer edge.
- SHOW, counter>0, freeze=0: counter decrements each clk.
- SHOW, counter==0, freeze=0:
  - Valid pending → back-to-back transfer, no blank gap.
  - None pending → state ← IDLE, disp_blank ← 1; disp_value/disp_src retain their last value.
- Each accepted value is displayed exactly HOLD_CYCLES cycles, absent freeze.
  - HOLD_CYCLES=1: counter is always 0; a new grant can occur every cycle.
- freeze=1:
  - req_ready all 0; counter, state and outputs hold.
  - Scheduling resumes the cycle after freeze falls.
- Simultaneous valids: exactly one grant per window, rotated fairly. A requester continuously valid waits at most N_REQ-1 holds.
- Requester rules (bench checks, RTL does not):
  - valid must not depend on ready.
  - value must be stable while valid and not yet accepted.
- req_valid falling without a transfer: no effect; the request is simply withdrawn.
- Counter width: $clog2(HOLD_CYCLES+1); no wrap-around is permitted.
- No X on any output after reset.

Test Plan:
All scenarios use N_REQ=4, HOLD_CYCLES=4.
1. Reset: assert rst mid-SHOW with counter=2 → same-cycle disp_blank=1, busy=0, req_ready=0000; after release, requester 0 is granted first.
2. Single requester: req_valid=0001, value=9 → req_ready[0] high in IDLE; from the next cycle disp_value=9, disp_src=0, disp_blank=0 for exactly 4 cycles. Then blank=1, busy=0 if valid has dropped.
3. Round-robin: all four valid with values 3,7,12,15 held → displayed order 0,1,2,3,0…, each 4 cycles, no blank gaps, one-hot req_ready pulses every 4 cycles.
4. Fairness after grant: last_grant=1, valids=0011 → next grant is requester 0, then 1.
5. Freeze: freeze=1 for 3 cycles at counter=1 → disp_value held 3 extra cycles (7 total), no req_ready asserted during freeze.
6. HOLD_CYCLES=1 variant: req_valid=0101 continuously → grants alternate 0,2 every cycle, disp_src toggles 0/2 each cycle.

Source files
------------

// File: rtl/display_scheduler_if.sv
// Requester handshake and display-path signals shared by the display scheduler.
// The master modport is the requester/display side; the slave modport is the scheduler.
interface display_scheduler_if #(
  parameter int N_REQ = 4
) ();
  localparam int SRC_W = $clog2(N_REQ);

  logic [N_REQ-1:0]   req_valid;
  logic [4*N_REQ-1:0] req_value;
  logic               freeze;
  logic [N_REQ-1:0]   req_ready;
  logic [3:0]         disp_value;
  logic [SRC_W-1:0]   disp_src;
  logic               disp_blank;
  logic               busy;

  modport master (
    output req_valid, req_value, freeze,
    input  req_ready, disp_value, disp_src, disp_blank, busy
  );

  modport slave (
    input  req_valid, req_value, freeze,
    output req_ready, disp_value, disp_src, disp_blank, busy
  );
endinterface

// File: rtl/display_scheduler.sv
// Round-robin arbiter sharing one 7-segment display path among N_REQ requesters;
// each accepted 4-bit value is held on the decoder input for HOLD_CYCLES clocks.
module display_scheduler #(
  parameter int N_REQ       = 4,
  parameter int HOLD_CYCLES = 50_000_000
) (
  input logic                 clk,
  input logic                 rst,
  display_scheduler_if.slave  bus
);
  localparam int SRC_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);

  typedef enum logic {IDLE, SHOW} state_t;

  state_t            state;
  logic [CNT_W-1:0]  counter;
  logic [SRC_W-1:0]  last_grant;
  logic [SRC_W-1:0]  winner;
  logic [SRC_W-1:0]  cand;
  logic              found;
  logic              window;
  logic              transfer;
  logic [N_REQ-1:0]  grant;
  int                idx;

  // Search starts just after the last winner so every requester gets its turn.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    cand   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx  = (int'(last_grant) + k) % N_REQ;
      cand = SRC_W'(idx);
      if (!found && bus.req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  assign window = ((state == IDLE) || (counter == '0)) && !bus.freeze;

  always_comb begin
    grant = '0;
    if (window && found && !rst)
      grant[winner] = 1'b1;
  end

  assign bus.req_ready = grant;
  assign transfer      = |(bus.req_valid & grant);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      counter        <= '0;
      last_grant     <= SRC_W'(N_REQ - 1);
      bus.disp_value <= '0;
      bus.disp_src   <= '0;
      bus.disp_blank <= 1'b1;
      bus.busy       <= 1'b0;
    end else if (!bus.freeze) begin
      if (transfer) begin
        state          <= SHOW;
        counter        <= CNT_W'(HOLD_CYCLES - 1);
        last_grant     <= winner;
        bus.disp_value <= bus.req_value[int'(winner)*4 +: 4];
        bus.disp_src   <= winner;
        bus.disp_blank <= 1'b0;
        bus.busy       <= 1'b1;
      end else if (state == SHOW) begin
        if (counter != '0) begin
          counter <= counter - CNT_W'(1);
        end else begin
          // Hold expired with nobody waiting: blank but keep the last value/source.
          state          <= IDLE;
          bus.disp_blank <= 1'b1;
          bus.busy       <= 1'b0;
        end
      end
    end
  end
endmodule
